// File: rtl/opti_pkg.sv
// Shared definitions for the result buffer: sample geometry, controller state
// encoding and the saturating magnitude helper used for peak tracking.
package opti_pkg;

  localparam int unsigned DATA_W = 24;    // sample width, two's complement
  localparam int unsigned DEPTH  = 2048;  // samples per block
  localparam int unsigned ADDR_W = 11;    // log2(DEPTH)

  typedef enum logic [1:0] {
    CAPT = 2'd0,
    HOLD = 2'd1,
    READ = 2'd2
  } state_e;

  // |x| in DATA_W bits; the most-negative value has no positive twin and
  // saturates to the largest positive value.
  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (x[DATA_W-1]) begin
      return -x;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/opti_result_buffer_if.sv
// Bus bundle of the result buffer: capture side (wr_*, filter_done), replay
// side (rd_* ready/valid) and the status outputs.
//   slave  : the buffer itself
//   master : the filter/host side driving writes and consuming replays
interface opti_result_buffer_if;
  import opti_pkg::*;

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              filter_done;
  logic              rd_start;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic [ADDR_W:0]   buf_count;
  logic              buf_full;
  logic [DATA_W-1:0] peak_abs;
  logic [ADDR_W-1:0] peak_idx;
  logic              busy;
  logic              ovf_err;

  modport slave (
    input  wr_valid, wr_data, filter_done, rd_start, rd_ready,
    output rd_valid, rd_data, rd_last, buf_count, buf_full, peak_abs, peak_idx, busy, ovf_err
  );

  modport master (
    output wr_valid, wr_data, filter_done, rd_start, rd_ready,
    input  rd_valid, rd_data, rd_last, buf_count, buf_full, peak_abs, peak_idx, busy, ovf_err
  );

endinterface

// File: rtl/opti_rd_skid.sv
// Two-entry output skid buffer for the replay port. Beats arrive from the
// synchronous RAM one cycle after issue; the producer only issues when a slot
// is guaranteed (via occ), so there is no in_ready.
//   clk, rst        : clock, async active-high reset
//   in_valid/data/last  : beat returned by the RAM
//   out_valid/data/last : replay beat, held stable until out_ready
//   occ             : entries currently held (0..2)
module opti_rd_skid
  import opti_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] ent_data [2];
  logic [1:0]        ent_last;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              pop;

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (in_valid) wr_ptr_q <= ~wr_ptr_q;
      if (pop)      rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, in_valid} - {1'b0, pop};
    end
  end

  // Payload needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      ent_data[wr_ptr_q] <= in_data;
      ent_last[wr_ptr_q] <= in_last;
    end
  end

  always_comb begin
    out_valid = (cnt_q != 2'd0);
    out_data  = out_valid ? ent_data[rd_ptr_q] : '0;
    out_last  = out_valid & ent_last[rd_ptr_q];
    occ       = cnt_q;
  end

endmodule

// File: rtl/opti_result_buffer.sv
// Result buffer: captures the filter output stream into a DEPTH x DATA_W RAM,
// tracks peak magnitude/index, then replays the block over a ready/valid port.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of opti_result_buffer_if (capture, replay, status)
module opti_result_buffer
  import opti_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  opti_result_buffer_if.slave bus
);

  localparam logic [ADDR_W:0] CntOne    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CntLastWr = (ADDR_W+1)'(DEPTH - 1);

  state_e            st_q, st_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] peak_q;
  logic [ADDR_W-1:0] idx_q;
  logic              ovf_q;
  logic [ADDR_W:0]   rd_ptr_q;
  logic              fetch_q, fetch_last_q;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en, issue, pop, done_beat;
  logic [1:0]        occ;
  logic [2:0]        pending;

  assign wr_en     = (st_q == CAPT) && bus.wr_valid;
  assign pop       = bus.rd_valid && bus.rd_ready;
  assign done_beat = pop && bus.rd_last;

  // Beats held or in flight after this cycle's pop; issue only while a skid
  // slot is guaranteed, which still allows one issue per cycle under ready.
  assign pending = {1'b0, occ} + {2'b0, fetch_q} - {2'b0, pop};
  assign issue   = (st_q == READ) && (rd_ptr_q < cnt_q) && (pending < 3'd2);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      CAPT: begin
        if (wr_en) cnt_d = cnt_q + CntOne;
        if (bus.filter_done || (wr_en && cnt_q == CntLastWr)) st_d = HOLD;
      end
      HOLD: begin
        if (bus.rd_start) st_d = (cnt_q != '0) ? READ : CAPT;
      end
      READ: begin
        if (done_beat) begin
          st_d  = CAPT;
          cnt_d = '0;
        end
      end
      default: st_d = CAPT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= CAPT;
      cnt_q        <= '0;
      peak_q       <= '0;
      idx_q        <= '0;
      ovf_q        <= 1'b0;
      rd_ptr_q     <= '0;
      fetch_q      <= 1'b0;
      fetch_last_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (bus.wr_valid && st_q != CAPT) ovf_q <= 1'b1;
      if (st_q == READ && done_beat) begin
        peak_q <= '0;
        idx_q  <= '0;
      end else if (wr_en && abs_sat(bus.wr_data) > peak_q) begin
        peak_q <= abs_sat(bus.wr_data);
        idx_q  <= cnt_q[ADDR_W-1:0];
      end
      if (st_q == HOLD && bus.rd_start) begin
        rd_ptr_q <= '0;
      end else if (issue) begin
        rd_ptr_q <= rd_ptr_q + CntOne;
      end
      fetch_q      <= issue;
      fetch_last_q <= issue && (rd_ptr_q == cnt_q - CntOne);
    end
  end

  // Simple dual-port RAM, one-cycle read latency, contents never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q[ADDR_W-1:0]] <= bus.wr_data;
    if (issue) mem_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  opti_rd_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fetch_q),
    .in_data   (mem_q),
    .in_last   (fetch_last_q),
    .out_valid (bus.rd_valid),
    .out_data  (bus.rd_data),
    .out_last  (bus.rd_last),
    .out_ready (bus.rd_ready),
    .occ       (occ)
  );

  assign bus.buf_count = cnt_q;
  assign bus.buf_full  = (cnt_q == (ADDR_W+1)'(DEPTH));
  assign bus.peak_abs  = peak_q;
  assign bus.peak_idx  = idx_q;
  assign bus.busy      = (st_q == READ);
  assign bus.ovf_err   = ovf_q;

endmodule

// File: doc/opti_result_buffer.md
Name: opti_result_buffer

Overview:
- Downstream neighbour of the filter control stage. Captures the filtered output stream (data_out / data_out_valid) into an on-chip 2048 x 24 sample memory.
- Tracks peak magnitude and its index during capture.
- After filter completion, replays the captured block over a ready/valid read port to the host/bench.
- Decouples the filter's fixed-rate output from a back-pressured consumer.

Parameters:
DATA_W, 24, sample width (two's complement)
DEPTH, 2048, samples per block
ADDR_W, 11, address width, equal to log2(DEPTH)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
wr_valid  in  1  input sample valid (driven by filter data_out_valid)
wr_data  in  DATA_W  input sample, signed
filter_done  in  1  end-of-block indication from filter control (level or pulse)
rd_start  in  1  one-cycle request to begin replay; only honoured in HOLD
rd_ready  in  1  consumer ready
rd_valid  out  1  replay sample valid
rd_data  out  DATA_W  replay sample, signed
rd_last  out  1  high with the final replay beat
buf_count  out  ADDR_W+1  samples captured in current block (0..DEPTH)
buf_full  out  1  buf_count == DEPTH
peak_abs  out  DATA_W  largest |sample| captured in current block
peak_idx  out  ADDR_W  index of the first sample reaching peak_abs
busy  out  1  high in READ
ovf_err  out  1  sticky: a write arrived outside CAPT; cleared only by rst

Behaviour:
Reset values:
- State CAPT. All outputs are 0, including buf_count, peak_abs, peak_idx, rd_*, busy and ovf_err.
- Memory contents are not cleared.
- Reset asserted mid-operation aborts capture or replay immediately. No partial beat survives.

States:
- CAPT: each cycle with wr_valid high writes wr_data to mem[buf_count] and increments buf_count (visible the next cycle).
  - Leave for HOLD on the edge where filter_done is high, or where the write makes buf_count reach DEPTH.
  - A write and filter_done in the same cycle: the write is stored first, then HOLD.
- HOLD: writes are dropped and set ovf_err.
  - rd_start with buf_count > 0 -> READ.
  - rd_start with buf_count == 0 -> CAPT (no beats issued).
- READ: replays mem[0 .. buf_count-1] in order.
  - busy = 1. Writes are dropped and set ovf_err.
  - After the handshake of the rd_last beat -> CAPT. On that transition buf_count, peak_abs and peak_idx clear to 0.

Read timing:
- Synchronous memory read, 1-cycle latency.
- rd_start sampled at edge T; rd_valid first high after edge T+2.
- Handshake = rd_valid & rd_ready.
- Sustained throughput is 1 beat/cycle while rd_ready stays high.
- While rd_ready is low, rd_valid, rd_data and rd_last hold stable.
- rd_valid never drops without a handshake.
- rd_last is asserted exactly on the beat with index buf_count-1.

Peak tracking (CAPT writes only):
- |x| computed in DATA_W bits. The most-negative input -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
- Update peak_abs/peak_idx only when |x| > peak_abs (strict), so the first occurrence wins.
- Results are registered, valid the cycle after the write.

Boundaries:
- No write is possible at buf_count == DEPTH (state has already left CAPT). The counter never wraps.
- filter_done arriving in HOLD or READ is ignored.
- rd_start arriving in CAPT or READ is ignored.

Decomposition:
- Shared package (opti_pkg): DATA_W, DEPTH, ADDR_W, and the state encoding CAPT=2'd0, HOLD=2'd1, READ=2'd2.
- One natural sub-module: opti_rd_skid, a 2-entry output skid buffer. It absorbs the memory read latency under rd_ready back-pressure so that 1 beat/cycle and stable hold are both met.
- Memory is an inferred simple dual-port RAM inside the top level.

Test Plan:
1. Capture and replay: write 2048 samples x = i - 1024, then pulse rd_start with rd_ready = 1.
   - HOLD is entered at count 2048 and buf_full = 1.
   - Exactly 2048 beats of i - 1024 in order, rd_last on beat 2047.
   - peak_abs = 1024, peak_idx = 0.
2. Early done: write 5 samples {3, -7, 7, 0, 1} and assert filter_done with the 5th write.
   - buf_count = 5, peak_abs = 7, peak_idx = 1.
   - Replay gives 5 beats, rd_last on value 1.
3. Back-pressure: during replay, toggle rd_ready in a 1-0-0-1 pattern.
   - rd_data and rd_valid hold while rd_ready is low.
   - No beat is lost or duplicated; sequence matches the written data.
4. Saturation: write -8388608 then 8388607.
   - peak_abs = 8388607, peak_idx = 0 (tie, first occurrence kept).
5. Overflow and empty:
   - A write while in HOLD sets ovf_err = 1 (sticky) and buf_count is unchanged.
   - filter_done with no writes, then rd_start: no rd_valid, returns to CAPT.
6. Reset mid-replay: assert rst at beat 100.
   - All outputs go to 0 and state returns to CAPT.
   - After reset, a new 4-sample capture replays correctly.
